// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared constants, state type and funct predicates for muldiv_unit
package muldiv_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(XLEN);

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    function automatic logic is_muldiv(input logic [5:0] funct);
        return funct inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};
    endfunction

    // Every funct that touches HI/LO and therefore must wait for a pending result
    function automatic logic is_hilo_op(input logic [5:0] funct);
        return is_muldiv(funct) || (funct inside {FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO});
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - one shift-add (mode=0) or restoring-divide (mode=1) step
module muldiv_iter
    import muldiv_pkg::*;
(
    input  logic                mode,
    input  logic [2*XLEN-1:0]   acc_i,
    input  logic [XLEN-1:0]     operand,
    output logic [2*XLEN-1:0]   acc_o
);

    logic [XLEN:0] sum;
    logic [XLEN:0] top;
    logic [XLEN:0] diff;

    always_comb begin
        // Multiply: {upper, multiplier}; add multiplicand on lsb then shift right with carry
        sum  = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, operand} : '0);
        // Divide: {remainder, dividend}; shift left one and trial-subtract the divisor
        top  = acc_i[2*XLEN-1:XLEN-1];
        diff = top - {1'b0, operand};
        if (mode) begin
            if (diff[XLEN]) begin
                acc_o = {top[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
            end else begin
                acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
            end
        end else begin
            acc_o = {sum, acc_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative mul/div sequencer with HI/LO registers and EX stall
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            op_valid,
    input  logic [5:0]      Funct,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            stall,
    output logic            busy,
    output logic [XLEN-1:0] HI,
    output logic [XLEN-1:0] LO,
    output logic [XLEN-1:0] mf_data
);

    state_t               state_q, state_d;
    logic                 busy_q, busy_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0]    acc_q, acc_d;
    logic [XLEN-1:0]      opb_q, opb_d;
    logic                 mode_q, mode_d;
    logic                 neg_q, neg_d;
    logic                 rneg_q, rneg_d;
    logic [XLEN-1:0]      hi_q, hi_d;
    logic [XLEN-1:0]      lo_q, lo_d;

    logic [2*XLEN-1:0]    acc_step;
    logic [2*XLEN-1:0]    prod_fix;
    logic [XLEN-1:0]      a_mag, b_mag;
    logic                 fn_div, fn_signed;

    muldiv_iter u_iter (
        .mode    (mode_q),
        .acc_i   (acc_q),
        .operand (opb_q),
        .acc_o   (acc_step)
    );

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        mode_d  = mode_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        fn_div    = Funct[1];
        fn_signed = ~Funct[0];
        a_mag     = (fn_signed && A[XLEN-1]) ? -A : A;
        b_mag     = (fn_signed && B[XLEN-1]) ? -B : B;
        prod_fix  = neg_q ? -acc_q : acc_q;

        case (state_q)
            IDLE: begin
                if (op_valid && !busy_q) begin
                    if (is_muldiv(Funct)) begin
                        if (fn_div && (B == '0)) begin
                            hi_d = A;
                            lo_d = '1;
                        end else begin
                            state_d = RUN;
                            busy_d  = 1'b1;
                            cnt_d   = '0;
                            mode_d  = fn_div;
                            opb_d   = b_mag;
                            acc_d   = {{XLEN{1'b0}}, a_mag};
                            neg_d   = fn_signed && (A[XLEN-1] ^ B[XLEN-1]);
                            rneg_d  = fn_signed && fn_div && A[XLEN-1];
                        end
                    end else if (Funct == FN_MTHI) begin
                        hi_d = A;
                    end else if (Funct == FN_MTLO) begin
                        lo_d = A;
                    end
                end
            end
            RUN: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(XLEN-1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                if (mode_q) begin
                    lo_d = neg_q  ? -acc_q[XLEN-1:0]      : acc_q[XLEN-1:0];
                    hi_d = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
                end else begin
                    hi_d = prod_fix[2*XLEN-1:XLEN];
                    lo_d = prod_fix[XLEN-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            mode_q  <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            mode_q  <= mode_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        case (Funct)
            FN_MFHI: mf_data = hi_q;
            FN_MFLO: mf_data = lo_q;
            default: mf_data = '0;
        endcase
    end

    assign stall = op_valid && busy_q && is_hilo_op(Funct);
    assign busy  = busy_q;
    assign HI    = hi_q;
    assign LO    = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [5:0]  Funct;
    logic [31:0] A, B;
    logic        stall, busy;
    logic [31:0] HI, LO, mf_data;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [63:0] sb[$];

    localparam logic [5:0] MFHI = 6'h10, MTHI = 6'h11, MFLO = 6'h12, MTLO = 6'h13;
    localparam logic [5:0] MULT = 6'h18, MULTU = 6'h19, DIV = 6'h1a, DIVU = 6'h1b;

    muldiv_unit dut (
        .clk      (clk),
        .reset    (reset),
        .op_valid (op_valid),
        .Funct    (Funct),
        .A        (A),
        .B        (B),
        .stall    (stall),
        .busy     (busy),
        .HI       (HI),
        .LO       (LO),
        .mf_data  (mf_data)
    );

    always #5 clk = ~clk;

    // Reference result as {HI, LO}
    function automatic logic [63:0] model(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb_, q, r;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        case (fn)
            MULT:    begin p = sa * sb_; return p; end
            MULTU:   return {32'b0, a} * {32'b0, b};
            DIV: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb_;
                r = sa % sb_;
                return {r[31:0], q[31:0]};
            end
            DIVU: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return 64'h0;
        endcase
    endfunction

    task automatic issue(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        op_valid = 1'b1;
        Funct    = fn;
        A        = a;
        B        = b;
        sb.push_back(exp);
        @(negedge clk);
        op_valid = 1'b0;
        Funct    = 6'h00;
    endtask

    task automatic wait_not_busy(output int cycles);
        cycles = 0;
        while (busy && cycles < 200) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; op_valid = 1'b0; Funct = MFLO; A = '0; B = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (stall !== 1'b0)  begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
        n_cmp++; if ({HI, LO} !== 64'h0) begin n_fail++; $display("FAIL reset_hilo: got %h expected 0", {HI, LO}); end
        n_cmp++; if (mf_data !== 32'h0) begin n_fail++; $display("FAIL reset_mf_data: got %h expected 0", mf_data); end
        Funct = 6'h00;
    endtask

    task automatic test_mthi_mfhi;
        op_valid = 1'b1; Funct = MTHI; A = 32'h0000_AAAA;
        @(negedge clk);
        Funct = MFHI; A = '0;
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mfhi_stall: got %b expected 0", stall); end
        n_cmp++; if (mf_data !== 32'h0000_AAAA) begin n_fail++; $display("FAIL mfhi_data: got %h expected 0000aaaa", mf_data); end
        Funct = MTLO; A = 32'h0000_5555;
        @(negedge clk);
        Funct = MFLO; A = '0;
        #1;
        n_cmp++; if (mf_data !== 32'h0000_5555) begin n_fail++; $display("FAIL mflo_data: got %h expected 00005555", mf_data); end
        op_valid = 1'b0; Funct = 6'h00;
        @(negedge clk);
    endtask

    task automatic test_plan_ops;
        logic [5:0]  fns [6] = '{MULT, DIVU, DIV, DIV, DIV, MULTU};
        logic [31:0] as  [6] = '{32'd7, 32'd100, 32'hFFFF_FFF9, 32'h1234, 32'h8000_0000, 32'd6};
        logic [31:0] bs  [6] = '{32'hFFFF_FFFD, 32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd9};
        logic [63:0] xs  [6] = '{64'hFFFF_FFFF_FFFF_FFEB, {32'd2, 32'd14}, 64'hFFFF_FFFF_FFFF_FFFD,
                                 {32'h1234, 32'hFFFF_FFFF}, {32'h0, 32'h8000_0000}, 64'd54};
        int cyc;
        logic [63:0] exp;
        for (int i = 0; i < 6; i++) begin
            issue(fns[i], as[i], bs[i], xs[i]);
            wait_not_busy(cyc);
            n_cmp++;
            if (cyc !== ((bs[i] == 0) ? 0 : 33)) begin
                n_fail++; $display("FAIL plan%0d_busy_cycles: got %0d expected %0d", i, cyc, (bs[i] == 0) ? 0 : 33);
            end
            exp = sb.pop_front();
            n_cmp++;
            if ({HI, LO} !== exp) begin
                n_fail++; $display("FAIL plan%0d_hilo: got %h expected %h", i, {HI, LO}, exp);
            end
        end
    endtask

    task automatic test_stall_mflo;
        int n;
        logic [63:0] exp;
        issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        op_valid = 1'b1; Funct = MFLO;
        #1;
        n = 0;
        while (stall && n < 200) begin
            n++;
            @(negedge clk);
            #1;
        end
        n_cmp++; if (n !== 33) begin n_fail++; $display("FAIL mflo_stall_cycles: got %0d expected 33", n); end
        n_cmp++; if (mf_data !== 32'h1) begin n_fail++; $display("FAIL mflo_after_stall: got %h expected 00000001", mf_data); end
        exp = sb.pop_front();
        n_cmp++; if ({HI, LO} !== exp) begin n_fail++; $display("FAIL multu_max_hilo: got %h expected %h", {HI, LO}, exp); end
        @(negedge clk);
        op_valid = 1'b0; Funct = 6'h00;
    endtask

    task automatic test_mtlo_during_busy;
        int n;
        logic [63:0] exp;
        issue(MULT, 32'h8765_4321, 32'h1234_5678, model(MULT, 32'h8765_4321, 32'h1234_5678));
        op_valid = 1'b1; Funct = MTLO; A = 32'h0000_DEAD;
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL mtlo_busy_stall: got %b expected 1", stall); end
        n = 0;
        while (stall && n < 200) begin
            n++;
            @(negedge clk);
            #1;
        end
        exp = sb.pop_front();
        n_cmp++; if ({HI, LO} !== exp) begin n_fail++; $display("FAIL mtlo_pending_result: got %h expected %h", {HI, LO}, exp); end
        @(negedge clk);
        op_valid = 1'b0; Funct = 6'h00; A = '0;
        n_cmp++; if ({HI, LO} !== {exp[63:32], 32'h0000_DEAD}) begin
            n_fail++; $display("FAIL mtlo_after_release: got %h expected %h", {HI, LO}, {exp[63:32], 32'h0000_DEAD});
        end
    endtask

    task automatic test_back_to_back;
        int n, cyc;
        logic [63:0] exp;
        issue(DIVU, 32'hDEAD_BEEF, 32'h0000_1234, model(DIVU, 32'hDEAD_BEEF, 32'h0000_1234));
        op_valid = 1'b1; Funct = DIV; A = 32'hF000_0001; B = 32'h0000_0013;
        sb.push_back(model(DIV, 32'hF000_0001, 32'h0000_0013));
        #1;
        n = 0;
        while (stall && n < 200) begin
            n++;
            @(negedge clk);
            #1;
        end
        n_cmp++; if (n !== 33) begin n_fail++; $display("FAIL b2b_stall_cycles: got %0d expected 33", n); end
        exp = sb.pop_front();
        n_cmp++; if ({HI, LO} !== exp) begin n_fail++; $display("FAIL b2b_first: got %h expected %h", {HI, LO}, exp); end
        @(negedge clk);
        op_valid = 1'b0; Funct = 6'h00;
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_no_dead_cycle: got %b expected 1", busy); end
        wait_not_busy(cyc);
        n_cmp++; if (cyc !== 33) begin n_fail++; $display("FAIL b2b_second_cycles: got %0d expected 33", cyc); end
        exp = sb.pop_front();
        n_cmp++; if ({HI, LO} !== exp) begin n_fail++; $display("FAIL b2b_second: got %h expected %h", {HI, LO}, exp); end
    endtask

    task automatic test_reset_mid;
        int cyc;
        logic [63:0] exp;
        op_valid = 1'b1; Funct = DIV; A = 32'h7FFF_0000; B = 32'h0000_0077;
        @(negedge clk);
        op_valid = 1'b0; Funct = 6'h00;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        n_cmp++; if ({HI, LO} !== 64'h0) begin n_fail++; $display("FAIL midreset_hilo: got %h expected 0", {HI, LO}); end
        repeat (40) @(negedge clk);
        n_cmp++; if ({HI, LO} !== 64'h0) begin n_fail++; $display("FAIL midreset_no_late_write: got %h expected 0", {HI, LO}); end
        issue(MULTU, 32'd3, 32'd5, 64'd15);
        wait_not_busy(cyc);
        exp = sb.pop_front();
        n_cmp++; if ({HI, LO} !== exp) begin n_fail++; $display("FAIL midreset_multu: got %h expected %h", {HI, LO}, exp); end
    endtask

    task automatic test_random;
        logic [5:0]  fn;
        logic [31:0] a, b;
        logic [63:0] exp;
        int cyc;
        for (int i = 0; i < 12; i++) begin
            fn = 6'h18 + 6'($urandom_range(0, 3));
            a  = $urandom;
            b  = (i % 4 == 3) ? 32'($urandom_range(0, 3)) : $urandom;
            if (i % 5 == 2) b = b >> 20;
            issue(fn, a, b, model(fn, a, b));
            wait_not_busy(cyc);
            exp = sb.pop_front();
            n_cmp++;
            if ({HI, LO} !== exp) begin
                n_fail++; $display("FAIL rand%0d fn=%h a=%h b=%h: got %h expected %h", i, fn, a, b, {HI, LO}, exp);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_mthi_mfhi();
        test_plan_ops();
        test_stall_mflo();
        test_mtlo_during_busy();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide sequencer and HI/LO register file for the pipelined MIPS core, sitting beside the EX-stage ALU. It accepts R-type `mult`, `multu`, `div`, `divu`, `mthi`, `mtlo`, `mfhi` and `mflo` from EX. Multiplies and divides take XLEN+1 cycles. While a result is pending, the block raises `stall` toward the hazard logic so dependent HI/LO accesses and new mul/div ops wait.

## Interface
- XLEN, 32, operand/HI/LO width; iteration count equals XLEN
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; clears state and HI/LO
- op_valid  in  1  EX holds a valid R-type (OpCode 6'h00) instruction
- Funct  in  6  instruction funct field
- A  in  XLEN  rs operand (forwarded)
- B  in  XLEN  rt operand (forwarded)
- stall  out  1  freeze IF/ID/EX this cycle; combinational
- busy  out  1  iteration in progress; registered
- HI  out  XLEN  HI register
- LO  out  XLEN  LO register
- mf_data  out  XLEN  HI when Funct=6'h10, LO when 6'h12, else 0; combinational

## Operation
- Funct codes handled: mfhi 10, mthi 11, mflo 12, mtlo 13, mult 18, multu 19, div 1a, divu 1b. Any other Funct is ignored.
- Accept condition: `op_valid && !busy` with a mul/div Funct.
  - Latch |A| and |B| for signed ops, raw values for unsigned ops.
  - Latch the sign-fix flags.
  - Clear the counter and go to RUN.
- FSM states and transitions:
  - IDLE -> RUN on accept.
  - RUN -> FIX after XLEN iterations.
  - FIX -> IDLE unconditionally; HI/LO are written on this transition.
- Multiply is shift-add with a 2·XLEN accumulator. HI gets the upper half, LO the lower half.
- Divide is restoring, one quotient bit per cycle. LO gets the quotient, HI the remainder.
- FIX-state sign correction:
  - mult: negate the 2·XLEN product if the operand signs differ.
  - div: negate the quotient if the signs differ; the remainder takes the sign of A.
- Divide by zero (B==0):
  - No iteration is done.
  - At the accept edge, HI←A and LO←all ones.
  - The FSM stays in IDLE and busy is never raised.
- Corner case: signed 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- mthi/mtlo with `op_valid && !busy`: write A into HI or LO at the clock edge.
- `stall = op_valid && busy && Funct ∈ {10,11,12,13,18,19,1a,1b}`. An op is held in EX while stalled and is accepted on the first cycle busy is low.
- mfhi/mflo read HI/LO combinationally when not stalled. A write-then-read in consecutive cycles sees the new value.

## Timing
- Reset values: state IDLE, busy 0, stall 0, HI 0, LO 0, counter 0, mf_data 0.
- Let accept happen at edge E0.
  - busy is high during cycles E0+1 … E0+XLEN+1 (33 cycles for XLEN=32).
  - HI/LO update at edge E0+XLEN+1; busy falls at the same edge.
- A stalled mfhi/mflo in cycle E0+XLEN+1 (FIX) still stalls. It reads the new value in the next cycle.
- Back-to-back mul/div: the second op is accepted in the first cycle after busy falls. There is no dead cycle.
- A mthi/mtlo issued while busy stalls. It never corrupts the pending result.
- Reset mid-operation aborts the iteration: HI/LO return to 0 and no write occurs.
- op_valid deasserting during RUN (flush of a younger instruction) has no effect on the running op.

## Structure
- Shared package `muldiv_pkg`:
  - funct constants FN_MFHI … FN_DIVU.
  - state enum {IDLE, RUN, FIX}.
  - helper predicate `is_muldiv(funct)`.
- Sub-module `muldiv_iter`: the single-step datapath, i.e. shift-add or restore/subtract, selected by a mode bit, over a 2·XLEN working register.
- The FSM, counter, sign fix, HI/LO registers and stall logic live in the top level.

## Test plan
- `mult` A=7, B=0xFFFFFFFD -> after 33 busy cycles, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- `divu` A=100, B=7 -> LO=14, HI=2; `div` A=0xFFFFFFF9 (−7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- `multu` 0xFFFFFFFF×0xFFFFFFFF followed immediately by `mflo` -> stall high for exactly 33 cycles; then mf_data=0x00000001 (HI=0xFFFFFFFE).
- `div` A=0x1234, B=0 -> HI=0x1234, LO=0xFFFFFFFF on the next edge; busy stays 0. Signed 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- `mthi` 0xAAAA then `mfhi` next cycle -> mf_data=0xAAAA with no stall. `mtlo` during busy -> stalled, and the final LO equals the mul/div result.
- Assert reset at cycle 10 of a `div` -> busy=0, HI=LO=0 next cycle; a following `multu` 3×5 gives LO=15, HI=0.
